hex_display_sequencer: RTL and testbench



---
 rtl/hex_display_sequencer_if.sv | 25 ++
 rtl/hex_display_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_hex_display_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/hex_display_sequencer_if.sv
// Bus bundle for hex_display_sequencer: the CPU-facing Avalon-MM slave and the
// write-only master that fans out to the HEX PIO instances.
interface hex_display_sequencer_if #(
  parameter int NUM_DIGITS = 6
);
  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic [NUM_DIGITS-1:0] hex_chipselect;
  logic [1:0]            hex_address;
  logic                  hex_write_n;
  logic [31:0]           hex_writedata;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, hex_chipselect, hex_address, hex_write_n, hex_writedata
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, hex_chipselect, hex_address, hex_write_n, hex_writedata
  );
endinterface

// File: rtl/hex_display_sequencer.sv
// Holds a hex value plus display options and replays it onto up to eight
// seven-segment PIOs, one single-cycle write per digit, LSD first.
module hex_display_sequencer #(
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hex_display_sequencer_if.slave  bus
);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1'b1);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t                state_r, state_nxt_s;
  logic [2:0]            digit_r, digit_nxt_s;
  logic [VW-1:0]         work_r, work_nxt_s;
  logic [1:0]            opts_r, opts_nxt_s;
  logic [VW-1:0]         value_r;
  logic                  blank_r, invert_r, pending_r, pending_nxt_s;
  logic                  wr_s, value_wr_s, ctrl_wr_s, req_s, take_s, busy_s;
  logic [31:0]           rd_s;
  logic [NUM_DIGITS-1:0] hex_cs_r, hex_cs_nxt_s;
  logic                  hex_wn_r, hex_wn_nxt_s;
  logic [6:0]            hex_seg_r, hex_seg_nxt_s;

  function automatic logic [6:0] seg7_f(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // A digit is blank only when it and every more-significant nibble are zero.
  function automatic logic [6:0] pattern_f(input logic [VW-1:0] w,
                                           input logic [1:0] o,
                                           input logic [2:0] d);
    logic [6:0] p;
    logic       nz;
    int         idx;
    idx = int'(d);
    nz  = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      nz = nz | ((j >= idx) && (w[4*j +: 4] != 4'h0));
    end
    if (o[0] && (idx != 0) && !nz) p = 7'h00;
    else                           p = seg7_f(w[4*idx +: 4]);
    return o[1] ? ~p : p;
  endfunction

  assign wr_s       = bus.chipselect && !bus.write_n;
  assign value_wr_s = wr_s && (bus.address == 2'd0);
  assign ctrl_wr_s  = wr_s && (bus.address == 2'd1);
  assign req_s      = value_wr_s || (ctrl_wr_s && bus.writedata[2]);
  assign busy_s     = (state_r != IDLE) || pending_r;

  generate
    if (VW < 32) begin : g_unused
      logic unused_wd_s;
      assign unused_wd_s = ^bus.writedata[31:VW];
    end
  endgenerate

  // A new request on the same edge the FSM takes the old one must survive.
  always_comb begin
    if (req_s)       pending_nxt_s = 1'b1;
    else if (take_s) pending_nxt_s = 1'b0;
    else             pending_nxt_s = pending_r;
  end

  // Software-visible registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_r   <= {VW{1'b0}};
      blank_r   <= 1'b0;
      invert_r  <= 1'b1;
      pending_r <= 1'b0;
    end else begin
      if (value_wr_s) value_r <= bus.writedata[VW-1:0];
      else            value_r <= value_r;
      if (ctrl_wr_s) begin
        blank_r  <= bus.writedata[0];
        invert_r <= bus.writedata[1];
      end else begin
        blank_r  <= blank_r;
        invert_r <= invert_r;
      end
      pending_r <= pending_nxt_s;
    end
  end

  // Slave read mux, zero-extended.
  always_comb begin
    rd_s = 32'h0000_0000;
    case (bus.address)
      2'd0:    rd_s[VW-1:0] = value_r;
      2'd1:    rd_s[1:0]    = {invert_r, blank_r};
      2'd2:    rd_s[1:0]    = {pending_r, busy_s};
      default: rd_s         = 32'h0000_0000;
    endcase
  end
  assign bus.readdata = rd_s;

  // FSM state register, including the snapshot the running sequence works from.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      digit_r <= 3'd0;
      work_r  <= {VW{1'b0}};
      opts_r  <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      digit_r <= digit_nxt_s;
      work_r  <= work_nxt_s;
      opts_r  <= opts_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    digit_nxt_s = digit_r;
    work_nxt_s  = work_r;
    opts_nxt_s  = opts_r;
    take_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (pending_r) begin
          state_nxt_s = WRITE;
          digit_nxt_s = 3'd0;
          work_nxt_s  = value_r;
          opts_nxt_s  = {invert_r, blank_r};
          take_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (digit_r == LAST_DIGIT) begin
          state_nxt_s = IDLE;
          digit_nxt_s = 3'd0;
        end else begin
          digit_nxt_s = digit_r + 3'd1;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic is driven from the next state so each strobe registers on the
  // same edge the FSM reaches that digit.
  always_comb begin
    hex_cs_nxt_s  = {NUM_DIGITS{1'b0}};
    hex_wn_nxt_s  = 1'b1;
    hex_seg_nxt_s = 7'h00;
    if (state_nxt_s == WRITE) begin
      hex_cs_nxt_s  = ONE_HOT0 << digit_nxt_s;
      hex_wn_nxt_s  = 1'b0;
      hex_seg_nxt_s = pattern_f(work_nxt_s, opts_nxt_s, digit_nxt_s);
    end else begin
      hex_wn_nxt_s  = 1'b1;
    end
  end

  // Registered PIO master outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_cs_r  <= {NUM_DIGITS{1'b0}};
      hex_wn_r  <= 1'b1;
      hex_seg_r <= 7'h00;
    end else begin
      hex_cs_r  <= hex_cs_nxt_s;
      hex_wn_r  <= hex_wn_nxt_s;
      hex_seg_r <= hex_seg_nxt_s;
    end
  end

  assign bus.hex_chipselect = hex_cs_r;
  assign bus.hex_write_n    = hex_wn_r;
  assign bus.hex_writedata  = {25'b0, hex_seg_r};
  assign bus.hex_address    = 2'b00;
endmodule

// File: tb/tb_hex_display_sequencer.sv
// Directed self-checking bench for hex_display_sequencer (NUM_DIGITS = 6).
module tb_hex_display_sequencer;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  logic [31:0] r;

  hex_display_sequencer_if #(.NUM_DIGITS(6)) bus ();

  hex_display_sequencer #(.NUM_DIGITS(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic drive_wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
  endtask

  task automatic release_wr();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // Leaves the caller 1 time unit after the sampling edge (E0).
  task automatic slv_write(input logic [1:0] a, input logic [31:0] d);
    drive_wr(a, d);
    @(posedge clk); #1;
    release_wr();
  endtask

  // exp = {d5,d4,d3,d2,d1,d0}; inj plants two VALUE writes during digits 2..3.
  task automatic run_seq(input string tag, input logic [41:0] exp, input logic inj,
                         input logic [31:0] end_status);
    logic [31:0] s;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk({tag, "_cs"},   32'(bus.hex_chipselect), 32'd1 << k);
      chk({tag, "_wn"},   {31'b0, bus.hex_write_n}, 32'd0);
      chk({tag, "_wd"},   bus.hex_writedata, {25'b0, exp[7*k +: 7]});
      chk({tag, "_addr"}, {30'b0, bus.hex_address}, 32'd0);
      rd(2'd2, s);
      chk({tag, "_busy"}, {31'b0, s[0]}, 32'd1);
      if (inj && k == 2) drive_wr(2'd0, 32'h0011_1111);
      else if (inj && k == 3) drive_wr(2'd0, 32'h0022_2222);
      else if (inj && k == 4) release_wr();
      else release_wr();
    end
    @(posedge clk); #1;
    chk({tag, "_end_cs"}, 32'(bus.hex_chipselect), 32'd0);
    chk({tag, "_end_wn"}, {31'b0, bus.hex_write_n}, 32'd1);
    rd(2'd2, s);
    chk({tag, "_end_status"}, s, end_status);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_n        = 1'b0;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;

    // Reset state.
    #12;
    chk("rst_cs", 32'(bus.hex_chipselect), 32'd0);
    chk("rst_wn", {31'b0, bus.hex_write_n}, 32'd1);
    chk("rst_wd", bus.hex_writedata, 32'd0);
    chk("rst_addr", {30'b0, bus.hex_address}, 32'd0);
    rd(2'd0, r); chk("rst_value", r, 32'd0);
    rd(2'd1, r); chk("rst_ctrl", r, 32'd2);
    rd(2'd2, r); chk("rst_status", r, 32'd0);
    rd(2'd3, r); chk("rst_addr3", r, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic: blank + invert.
    slv_write(2'd1, 32'h3);
    rd(2'd1, r); chk("ctrl_rb", r, 32'd3);
    rd(2'd2, r); chk("ctrl_nopend", r, 32'd0);
    slv_write(2'd0, 32'h0000_012A);
    rd(2'd2, r); chk("basic_e0_status", r, 32'd3);
    rd(2'd0, r); chk("basic_value_rb", r, 32'h0000_012A);
    run_seq("basic", {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h08}, 1'b0, 32'd0);

    // Plain encoding of A..F.
    slv_write(2'd1, 32'h0);
    slv_write(2'd0, 32'h00FE_DCBA);
    run_seq("plain", {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77}, 1'b0, 32'd0);

    // Back-to-back: writes during the run; last one wins after one idle cycle.
    slv_write(2'd0, 32'h0000_0345);
    run_seq("b2b_first", {7'h3F, 7'h3F, 7'h3F, 7'h4F, 7'h66, 7'h6D}, 1'b1, 32'd3);
    rd(2'd0, r); chk("b2b_value_rb", r, 32'h0022_2222);
    run_seq("b2b_second", {7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B, 7'h5B}, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("b2b_no_third", 32'(bus.hex_chipselect), 32'd0);
    end

    // Blanking boundaries: interior zeros stay lit, top zero blanks.
    slv_write(2'd1, 32'h1);
    slv_write(2'd0, 32'h0001_0200);
    run_seq("blank_mid", {7'h00, 7'h06, 7'h3F, 7'h5B, 7'h3F, 7'h3F}, 1'b0, 32'd0);
    slv_write(2'd0, 32'h0);
    run_seq("blank_zero", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 1'b0, 32'd0);

    // Refresh via CTRL bit2, which never reads back.
    slv_write(2'd1, 32'h5);
    rd(2'd1, r); chk("refresh5_rb", r, 32'd1);
    run_seq("refresh5", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F}, 1'b0, 32'd0);
    slv_write(2'd1, 32'h4);
    rd(2'd1, r); chk("refresh4_rb", r, 32'd0);
    run_seq("refresh4", {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0, 32'd0);

    // Address 3 ignores writes.
    slv_write(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, r); chk("addr3_rb", r, 32'd0);
    rd(2'd2, r); chk("addr3_nopend", r, 32'd0);

    // Reset mid-sequence.
    slv_write(2'd0, 32'h0012_3456);
    @(posedge clk); #1;
    chk("mid_hex0_wd", bus.hex_writedata, 32'h7D);
    @(posedge clk); #1;
    chk("mid_hex1_cs", 32'(bus.hex_chipselect), 32'd2);
    chk("mid_hex1_wd", bus.hex_writedata, 32'h6D);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cs", 32'(bus.hex_chipselect), 32'd0);
    chk("mid_rst_wn", {31'b0, bus.hex_write_n}, 32'd1);
    chk("mid_rst_wd", bus.hex_writedata, 32'd0);
    rd(2'd1, r); chk("mid_rst_ctrl", r, 32'd2);
    rd(2'd2, r); chk("mid_rst_status", r, 32'd0);
    rd(2'd0, r); chk("mid_rst_value", r, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("post_rst_quiet", {25'b0, bus.hex_write_n, 32'(bus.hex_chipselect) == 32'd0 ? 6'd0 : 6'h3F},
          {25'b0, 1'b1, 6'd0});
    end
    rd(2'd2, r); chk("post_rst_status", r, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
